// File: rtl/alu_md_iter.sv
// Integer ALU with an iterative RV32M multiply/divide unit.
// Base ops finish in one registered cycle. M ops run a DATA_WIDTH-step
// shift-add / restoring-divide loop plus one sign fix-up cycle.
// The input and output both use valid/ready handshakes.
module alu_md_iter #(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 5,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   ALUControl,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(17);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  steps_done_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic                  neg_q;
    logic [DW-1:0]         acc_hi_q;
    logic [DW-1:0]         acc_lo_q;
    logic [DW-1:0]         opnd_q;
    logic [DW-1:0]         res_q;
    logic                  zero_q;

    logic                  accept;
    logic                  is_mop;
    logic                  is_div_q;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DW-1:0]         alu_d;
    logic                  a_neg, b_neg;
    logic [DW-1:0]         a_abs, b_abs;
    logic [DW-1:0]         a_mag_d, b_mag_d;
    logic                  neg_d;
    logic [DW:0]           mul_sum;
    logic [DW-1:0]         mul_hi_d, mul_lo_d;
    logic [DW:0]           div_rem;
    logic [DW-1:0]         div_diff;
    logic                  div_ge;
    logic [DW-1:0]         div_hi_d, div_lo_d;
    logic [2*DW-1:0]       prod_s;
    logic [DW-1:0]         quo_s, rem_s;
    logic [DW-1:0]         fin_d;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign is_mop    = (ALUControl >= OP_MUL) && (ALUControl <= OP_REMU);
    assign is_div_q  = (op_q >= OP_DIV);
    assign shamt     = SrcB[SHAMT_WIDTH-1:0];

    // Single-cycle base ALU result, registered on accept
    always_comb begin
        alu_d = '0;
        case (ALUControl)
            OP_ADD:  alu_d = SrcA + SrcB;
            OP_SUB:  alu_d = SrcA - SrcB;
            OP_SLL:  alu_d = SrcA << shamt;
            OP_SLT:  alu_d = {{(DW-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: alu_d = {{(DW-1){1'b0}}, (SrcA < SrcB)};
            OP_XOR:  alu_d = SrcA ^ SrcB;
            OP_SRL:  alu_d = SrcA >> shamt;
            OP_SRA:  alu_d = $signed(SrcA) >>> shamt;
            OP_OR:   alu_d = SrcA | SrcB;
            OP_AND:  alu_d = SrcA & SrcB;
            default: alu_d = '0;
        endcase
    end

    // Operand magnitudes and result sign for the M-op loop
    always_comb begin
        a_neg   = SrcA[DW-1];
        b_neg   = SrcB[DW-1];
        a_abs   = a_neg ? (~SrcA + 1'b1) : SrcA;
        b_abs   = b_neg ? (~SrcB + 1'b1) : SrcB;
        a_mag_d = SrcA;
        b_mag_d = SrcB;
        neg_d   = 1'b0;
        case (ALUControl)
            OP_MULH: begin
                a_mag_d = a_abs;
                b_mag_d = b_abs;
                neg_d   = a_neg ^ b_neg;
            end
            OP_MULHSU: begin
                a_mag_d = a_abs;
                neg_d   = a_neg;
            end
            // A zero divisor yields an all-ones quotient whatever the dividend sign
            OP_DIV: begin
                a_mag_d = a_abs;
                b_mag_d = b_abs;
                neg_d   = (a_neg ^ b_neg) & (SrcB != '0);
            end
            OP_REM: begin
                a_mag_d = a_abs;
                b_mag_d = b_abs;
                neg_d   = a_neg;
            end
            default: ;
        endcase
    end

    // One multiply and one divide iteration step, plus the sign fix-up of the final value
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_d = mul_sum[DW:1];
        mul_lo_d = {mul_sum[0], acc_lo_q[DW-1:1]};

        div_rem  = {acc_hi_q, acc_lo_q[DW-1]};
        div_ge   = (div_rem >= {1'b0, opnd_q});
        div_diff = div_rem[DW-1:0] - opnd_q;
        div_hi_d = div_ge ? div_diff : div_rem[DW-1:0];
        div_lo_d = {acc_lo_q[DW-2:0], div_ge};

        prod_s = neg_q ? (~{acc_hi_q, acc_lo_q} + 1'b1) : {acc_hi_q, acc_lo_q};
        quo_s  = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_s  = neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

        fin_d = '0;
        case (op_q)
            OP_MUL:                        fin_d = prod_s[DW-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_d = prod_s[2*DW-1:DW];
            OP_DIV, OP_DIVU:               fin_d = quo_s;
            OP_REM, OP_REMU:               fin_d = rem_s;
            default:                       fin_d = '0;
        endcase
    end

    // Control FSM and all datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            steps_done_q <= 1'b0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            acc_hi_q     <= '0;
            acc_lo_q     <= '0;
            opnd_q       <= '0;
            res_q        <= '0;
            zero_q       <= 1'b1;
        end else if (flush) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            steps_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_mop) begin
                            op_q         <= ALUControl;
                            neg_q        <= neg_d;
                            acc_hi_q     <= '0;
                            acc_lo_q     <= a_mag_d;
                            opnd_q       <= b_mag_d;
                            cnt_q        <= CW'(DW - 1);
                            steps_done_q <= 1'b0;
                            state_q      <= S_BUSY;
                        end else begin
                            res_q   <= alu_d;
                            zero_q  <= (alu_d == '0);
                            state_q <= S_DONE;
                        end
                    end else if (state_q == S_DONE && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                // Steps run at counts DW-1..0; the following cycle does the fix-up,
                // giving a DW+1 cycle latency from accept to out_valid.
                S_BUSY: begin
                    if (!steps_done_q) begin
                        acc_hi_q <= is_div_q ? div_hi_d : mul_hi_d;
                        acc_lo_q <= is_div_q ? div_lo_d : mul_lo_d;
                        if (cnt_q == '0) begin
                            steps_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end else begin
                        res_q        <= fin_d;
                        zero_q       <= (fin_d == '0);
                        steps_done_q <= 1'b0;
                        state_q      <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md_iter.sv
// Self-checking bench for alu_md_iter (DATA_WIDTH=32): table vectors, directed
// multi-cycle sequences and random traffic, checked through an expected-result queue.
module tb_alu_md_iter;

    localparam int W = 32;

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3,
                           OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                           OP_OR = 5'd8, OP_AND = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11,
                           OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14,
                           OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    ALUControl = '0;
    logic [W-1:0]  SrcA = '0;
    logic [W-1:0]  SrcB = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  ALUResult;
    logic          Zero;

    alu_md_iter #(.DATA_WIDTH(W), .OP_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb[$];
    int           tests = 0;
    int           failed = 0;
    int           pops = 0;
    bit           rnd_active = 1'b0;

    task automatic check32(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        failed++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Independent reference built on native wide arithmetic
    function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0]        pu;
        logic signed [2*W-1:0] ps;
        logic [W-1:0]          r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << b[4:0];
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  r = a ^ b;
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $signed(a) >>> b[4:0];
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_MUL: begin
                pu = {32'b0, a} * {32'b0, b};
                r  = pu[W-1:0];
            end
            OP_MULH: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r  = ps[2*W-1:W];
            end
            OP_MULHSU: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                r  = ps[2*W-1:W];
            end
            OP_MULHU: begin
                pu = {32'b0, a} * {32'b0, b};
                r  = pu[2*W-1:W];
            end
            OP_DIV: begin
                if (b == '0) r = '1;
                else if (a == 32'h8000_0000 && b == '1) r = a;
                else r = $signed(a) / $signed(b);
            end
            OP_DIVU: r = (b == '0) ? '1 : a / b;
            OP_REM: begin
                if (b == '0) r = a;
                else if (a == 32'h8000_0000 && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
            end
            OP_REMU: r = (b == '0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'(($urandom_range(0, 40)));
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
        int unsigned n;
        n = 0;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout_fail("send_in_ready");
        else sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            timeout_fail(name);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pop and compare on every completed output handshake
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_output: got %h expected no output", ALUResult);
            end else begin
                e = sb.pop_front();
                check32("result", ALUResult, e);
                check1("zero", Zero, (e == '0));
                pops++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int lat;
        bit seen;
        logic [4:0] rop;
        logic [W-1:0] ra, rb;

        vecs.push_back('{OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000});
        vecs.push_back('{OP_SUB,    32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE});
        vecs.push_back('{OP_SLL,    32'h0000_0001, 32'h0000_001F, 32'h8000_0000});
        vecs.push_back('{OP_SLL,    32'h0000_0001, 32'h0000_0021, 32'h0000_0002});
        vecs.push_back('{OP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
        vecs.push_back('{OP_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0});
        vecs.push_back('{OP_SRL,    32'h8000_0000, 32'h0000_0004, 32'h0800_0000});
        vecs.push_back('{OP_SRA,    32'h8000_0000, 32'h0000_0004, 32'hF800_0000});
        vecs.push_back('{OP_OR,     32'h1234_0000, 32'h0000_5678, 32'h1234_5678});
        vecs.push_back('{OP_AND,    32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000});
        vecs.push_back('{5'd18,     32'h1234_5678, 32'h1111_1111, 32'h0000_0000});
        vecs.push_back('{5'd31,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9});
        vecs.push_back('{OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E});
        vecs.push_back('{OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002});
        vecs.push_back('{OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
        vecs.push_back('{OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001});

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("reset_out_valid", out_valid, 1'b0);
        check32("reset_result", ALUResult, '0);
        check1("reset_zero", Zero, 1'b1);
        check1("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops, one result per cycle
        p0 = pops;
        send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        send(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        @(negedge clk);
        #1;
        check1("b2b_out_valid", out_valid, 1'b1);
        check32("b2b_result_count", 32'(pops), 32'(p0 + 2));
        wait_drain("b2b_drain");

        // MULH latency: accept edge to first out_valid
        send(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            #1;
            if (k == 5) check1("busy_in_ready", in_ready, 1'b0);
            if (out_valid) begin
                lat = k - 1;
                break;
            end
        end
        check32("mulh_latency", 32'(lat), 32'(W + 1));
        wait_drain("mulh_drain");

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_drain("table_drain");
        end

        // Output held stable while the consumer stalls
        out_ready = 1'b0;
        send(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = out_valid;
        end
        if (!seen) timeout_fail("hold_wait_valid");
        for (int k = 0; k < 10; k++) begin
            check32("hold_result", ALUResult, 32'hFFFF_FFFD);
            check1("hold_out_valid", out_valid, 1'b1);
            check1("hold_in_ready", in_ready, 1'b0);
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("hold_drain");

        // Flush wins over a same-cycle accept in IDLE
        flush = 1'b1;
        in_valid = 1'b1;
        ALUControl = OP_ADD;
        SrcA = 32'd3;
        SrcB = 32'd4;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check1("flush_idle_out_valid", out_valid, 1'b0);
        check1("flush_idle_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Flush during BUSY with a request pending; neither op may produce output
        send(OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        ALUControl = OP_ADD;
        SrcA = 32'd1;
        SrcB = 32'd1;
        @(negedge clk);
        #1;
        check1("flush_busy_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        check1("flush_busy_idle", in_ready, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
            #1;
        end
        check1("flush_no_output", seen, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a MUL
        send(OP_ADD, 32'd1, 32'd2, 32'd3);
        wait_drain("pre_reset_drain");
        send(OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check1("async_rst_out_valid", out_valid, 1'b0);
        check32("async_rst_result", ALUResult, '0);
        check1("async_rst_zero", Zero, 1'b1);
        check1("async_rst_in_ready", in_ready, 1'b1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic with a randomly stalling consumer
        rnd_active = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    rop = 5'($urandom_range(0, 20));
                    ra  = pick();
                    rb  = pick();
                    send(rop, ra, rb, model(rop, ra, rb));
                end
                rnd_active = 1'b0;
            end
            begin
                while (rnd_active) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
